// File: rtl/memctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// Optional power-on clear of the array is enabled with the MEMCTRL_CLEAR_EN macro.
package memctrl_pkg;

  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_ADDR_W        = 3;
  localparam int unsigned DEF_SETUP_CYCLES  = 1;
  localparam int unsigned DEF_ACCESS_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RESP,
    CLEAR_SETUP,
    CLEAR_ACCESS,
    CLEAR_HOLD
  } state_e;

  // The phase counter is loaded with (length - 1) and advances at zero.
  function automatic int unsigned phase_cnt_w(input int unsigned setup_c,
                                              input int unsigned access_c);
    int unsigned m;
    m = (setup_c > access_c) ? setup_c : access_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/memctrl_phase_timer.sv
// Loadable down-counter timing SETUP/ACCESS phases; done_o is high when the
// count is zero. Saturates at zero, so it cannot wrap.
module memctrl_phase_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/memory_access_controller.sv
// Serialising sequencer in front of the memorycell array: setup/access/hold
// strobe timing and a one-cycle response. MEMCTRL_CLEAR_EN adds a zero-fill after reset.
module memory_access_controller
  import memctrl_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_input,
  input  logic [DATA_W-1:0] mem_data_output
);

  localparam int unsigned CNT_W = phase_cnt_w(SETUP_CYCLES, ACCESS_CYCLES);

  state_e            state_q, state_d;
  logic              phase_done;
  logic              phase_load;
  logic [CNT_W-1:0]  phase_val;
  logic              accept;

  logic              mem_select_q, mem_select_d;
  logic              mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              init_done_q, init_done_d;
`ifdef MEMCTRL_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  memctrl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (phase_load),
    .load_val_i(phase_val),
    .done_o    (phase_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef MEMCTRL_CLEAR_EN
        if (!init_done_q) begin
          state_d = CLEAR_SETUP;
        end else if (req_valid) begin
          state_d = SETUP;
        end
`else
        if (req_valid && init_done_q) begin
          state_d = SETUP;
        end
`endif
      end
      SETUP:  if (phase_done) state_d = ACCESS;
      ACCESS: if (phase_done) state_d = HOLD;
      HOLD:   state_d = RESP;
      RESP:   state_d = IDLE;
`ifdef MEMCTRL_CLEAR_EN
      CLEAR_SETUP:  if (phase_done) state_d = CLEAR_ACCESS;
      CLEAR_ACCESS: if (phase_done) state_d = CLEAR_HOLD;
      CLEAR_HOLD:   state_d = (clr_addr_q == '1) ? IDLE : CLEAR_SETUP;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Select is registered from the next state so the strobe leaves a flop directly.
  always_comb begin
    req_ready    = (state_q == IDLE) && init_done_q;
    rsp_valid    = (state_q == RESP);
    mem_select_d = (state_d == ACCESS) || (state_d == CLEAR_ACCESS);
    phase_load   = (state_d != state_q);
    case (state_d)
      SETUP, CLEAR_SETUP:   phase_val = CNT_W'(SETUP_CYCLES - 1);
      ACCESS, CLEAR_ACCESS: phase_val = CNT_W'(ACCESS_CYCLES - 1);
      default:              phase_val = '0;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    if (accept) begin
      mem_op_d   = req_write;
      mem_addr_d = req_addr;
      mem_data_d = req_wdata;
    end
    if ((state_q == ACCESS) && phase_done) begin
      rsp_rdata_d = mem_op_q ? '0 : mem_data_output;
    end
`ifdef MEMCTRL_CLEAR_EN
    clr_addr_d = clr_addr_q;
    if ((state_q == IDLE) && !init_done_q) begin
      mem_op_d   = 1'b1;
      mem_addr_d = clr_addr_q;
      mem_data_d = '0;
    end
    // Next clear address is presented on the HOLD exit edge, ahead of its SETUP phase.
    if (state_q == CLEAR_HOLD) begin
      if (clr_addr_q == '1) begin
        init_done_d = 1'b1;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
        mem_op_d   = 1'b1;
        mem_addr_d = clr_addr_q + 1'b1;
        mem_data_d = '0;
      end
    end
`else
    init_done_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_select_q <= 1'b0;
      mem_op_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rsp_rdata_q  <= '0;
      init_done_q  <= 1'b0;
`ifdef MEMCTRL_CLEAR_EN
      clr_addr_q   <= '0;
`endif
    end else begin
      mem_select_q <= mem_select_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      rsp_rdata_q  <= rsp_rdata_d;
      init_done_q  <= init_done_d;
`ifdef MEMCTRL_CLEAR_EN
      clr_addr_q   <= clr_addr_d;
`endif
    end
  end

  assign mem_select     = mem_select_q;
  assign mem_op         = mem_op_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_input = mem_data_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign init_done      = init_done_q;

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequencing stage directly upstream of the memorycell array.
- Accepts word-level read/write requests over a valid/ready handshake.
- Drives the memorycell strobes (op, select, address, data_input) with guaranteed setup/access/hold timing, samples data_output on reads, and returns a one-cycle response.
- Serialises all memory traffic: one transaction in flight at a time.

Parameters:
- DATA_W, 8: data word width; matches memorycell data_input/data_output.
- ADDR_W, 3: address width; array depth 2**ADDR_W.
- SETUP_CYCLES, 1: cycles address/op/data are stable before select rises; must be at least 1.
- ACCESS_CYCLES, 2: cycles select is held high; must be at least 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data; ignored on reads.
- rsp_valid  out  1  one-cycle pulse at transaction completion.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads; 0 on writes.
- init_done  out  1  controller initialised, requests may be issued.
- mem_op  out  1  to memorycell op (1 = write).
- mem_select  out  1  to memorycell select.
- mem_address  out  ADDR_W  to memorycell address.
- mem_data_input  out  DATA_W  to memorycell data_input.
- mem_data_output  in  DATA_W  from memorycell data_output.

Behaviour:
- Reset (asynchronous assert): all outputs 0 immediately, including mem_select, req_ready, rsp_valid and init_done. State goes to IDLE.
- Reset mid-transaction: the in-flight transaction is dropped with no response; mem_select falls immediately.
- States: IDLE, SETUP, ACCESS, HOLD, RESP, plus CLEAR_* when the optional feature is enabled.
- IDLE:
  - req_ready = init_done.
  - Accept on the clock edge where req_valid && req_ready; latch write/addr/wdata into internal registers.
  - mem_address, mem_op and mem_data_input take the latched values on that same edge.
  - Go to SETUP.
- SETUP: mem_select = 0 for SETUP_CYCLES cycles; then go to ACCESS.
- ACCESS:
  - mem_select = 1 for ACCESS_CYCLES cycles.
  - Reads: register mem_data_output into rsp_rdata on the edge that ends the last ACCESS cycle.
  - Then go to HOLD.
- HOLD: mem_select = 0 for 1 cycle; address, op and data remain unchanged. Then go to RESP.
- RESP: rsp_valid = 1 for exactly 1 cycle; then go to IDLE.
  - rsp_rdata is held until the next read's capture.
  - rsp_rdata is cleared to 0 on write completion.
- Memory outputs between transactions: mem_op, mem_address and mem_data_input keep their last values; mem_select stays 0.
- req_ready is 0 in every state except IDLE; no request is accepted during RESP.
- Latency: rsp_valid is high in the cycle beginning SETUP_CYCLES+ACCESS_CYCLES+1 edges after the acceptance edge (4 with defaults).
- Throughput: at most one transaction per SETUP_CYCLES+ACCESS_CYCLES+3 cycles (6 with defaults).
- Glitch-free strobe: mem_select is a direct flop output. address, op and data never change while mem_select = 1.
- Phase counter: down-counter wide enough for max(SETUP_CYCLES, ACCESS_CYCLES). It loads on each phase entry and moves to the next state at 0; no wrap is possible.
- Any req_* change while req_ready = 0 is ignored.

Optional Feature:
- Macro MEMCTRL_CLEAR_EN.
- Defined:
  - After reset release, the controller walks addresses 0 to 2**ADDR_W-1, writing 0 to each.
  - Each write uses the same SETUP/ACCESS/HOLD timing, with no RESP phase and no rsp_valid.
  - init_done rises in the cycle after the last HOLD.
  - The address counter saturates at the top address and does not wrap.
  - Reset during the clear restarts it from address 0.
- Undefined: init_done is set on the first clock edge after reset release; no clear states exist.

Decomposition:
- Package memctrl_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, HOLD, RESP, CLEAR_SETUP, CLEAR_ACCESS, CLEAR_HOLD);
  - default width constants (DATA_W = 8, ADDR_W = 3);
  - phase-length defaults.
- One natural sub-module, memctrl_phase_timer: loadable down-counter with a done flag, shared by the request path and the clear path.

Test Plan:
- Reset, then a write request addr=3'b100, data=8'hAA -> req_ready falls. mem_select is high for exactly 2 cycles, with mem_op=1, addr=4 and data=AA stable from 1 cycle before to 1 cycle after. rsp_valid pulses 4 edges after acceptance with rsp_rdata=0.
- Read addr=3'b100 after that write -> mem_op=0 during the access; rsp_rdata=8'hAA with rsp_valid.
- Writes 8'h01..8'h08 to addresses 0..7, then reads back all 8 -> every readback matches; back-to-back requests are accepted every 6 cycles, never earlier.
- rst_n driven low during ACCESS -> mem_select and req_ready fall asynchronously. No rsp_valid is produced; after release, a new read succeeds.
- req_valid held high continuously with changing req_addr -> only values present at acceptance edges are used.
- MEMCTRL_CLEAR_EN defined: preload memory model with 8'hFF, then reset -> 8 zero writes occur and init_done rises after them. req_ready stays 0 until then; readback of address 7 returns 8'h00.
